// File: rtl/norm_engine.sv
// norm_engine: reduces a RAM index range to a sum of squares, sum of |x| or max |x|.
// The host owns the single RAM port whenever controlArr is high; element issue stalls meanwhile.
module norm_engine #(
    parameter int DATA_W = 27,
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     r_enable,
    input  logic [1:0]               mode,
    input  logic [ADDR_W-1:0]        init_i,
    input  logic [ADDR_W-1:0]        init_end,
    input  logic signed [ACC_W-1:0]  init_acc,
    input  logic                     controlArr,
    input  logic                     controlArrWEnable,
    input  logic [ADDR_W-1:0]        controlArrAddr,
    input  logic signed [DATA_W-1:0] controlArrWData,
    output logic signed [DATA_W-1:0] controlArrRData,
    output logic                     w_enable,
    output logic                     busy,
    output logic                     overflow,
    output logic signed [ACC_W-1:0]  result
);

    if (ADDR_W < $clog2(DEPTH + 1)) begin : g_bad_addr_w
        $error("norm_engine: ADDR_W too small to hold DEPTH");
    end
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
        $error("norm_engine: ACC_W must be at least 2*DATA_W");
    end

    localparam logic [ADDR_W-1:0]       DEPTH_A = ADDR_W'(DEPTH);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                mode_q;
    logic [ADDR_W-1:0]         idx_q, end_q, idx_next, end_clamp, ram_addr, rd_addr_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d, term_q, term_d, result_q;
    logic                      overflow_q, sat;
    logic                      v_rd_q, v_op_q, v_acc_q;
    logic                      start, range_empty, issue, ram_we;
    logic signed [DATA_W-1:0]  mem [DEPTH];
    logic signed [DATA_W-1:0]  rd_data;
    logic signed [2*DATA_W-1:0] x_wide, x_sq;
    logic signed [DATA_W:0]    x_ext, x_abs;
    logic signed [ACC_W:0]     sum_ext;

    // Host has priority on the RAM port; out-of-range host writes are dropped.
    assign ram_addr = controlArr ? controlArrAddr : idx_q;
    assign ram_we   = controlArr && controlArrWEnable && (controlArrAddr < DEPTH_A);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= controlArrWData;
        end
        rd_addr_q <= ram_addr;
    end

    assign rd_data         = mem[rd_addr_q];
    assign controlArrRData = rd_data;

    assign start       = r_enable && (state_q == StIdle || state_q == StDone);
    assign end_clamp   = (init_end > DEPTH_A) ? DEPTH_A : init_end;
    assign range_empty = (mode_q == 2'd3) || (idx_q >= end_q);
    assign issue       = (state_q == StRun) && !range_empty && !controlArr;
    assign idx_next    = idx_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start) state_d = StRun;
            StRun: begin
                if (range_empty || (issue && idx_next == end_q)) state_d = StDrain;
            end
            StDrain: if (!(v_rd_q || v_op_q || v_acc_q)) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Per-element term; |x| keeps one extra bit so the most negative value is exact.
    always_comb begin
        x_wide = (2 * DATA_W)'(rd_data);
        x_sq   = x_wide * x_wide;
        x_ext  = {rd_data[DATA_W-1], rd_data};
        x_abs  = x_ext[DATA_W] ? -x_ext : x_ext;
        term_d = (mode_q == 2'd0) ? ACC_W'(x_sq) : ACC_W'(x_abs);
    end

    // Terms are never negative, so only positive saturation is possible.
    always_comb begin
        sum_ext = {acc_q[ACC_W-1], acc_q} + {term_q[ACC_W-1], term_q};
        sat     = 1'b0;
        acc_d   = acc_q;
        if (mode_q == 2'd2) begin
            if (term_q > acc_q) acc_d = term_q;
        end else if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_d = ACC_MAX;
            sat   = 1'b1;
        end else begin
            acc_d = sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            idx_q      <= '0;
            end_q      <= '0;
            acc_q      <= '0;
            term_q     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            v_rd_q     <= 1'b0;
            v_op_q     <= 1'b0;
            v_acc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            v_rd_q  <= issue;
            v_op_q  <= v_rd_q;
            v_acc_q <= v_op_q;
            if (v_rd_q) term_q <= term_d;
            if (start) begin
                mode_q     <= mode;
                idx_q      <= init_i;
                end_q      <= end_clamp;
                acc_q      <= init_acc;
                overflow_q <= 1'b0;
            end else begin
                if (issue) idx_q <= idx_next;
                if (v_op_q) begin
                    acc_q <= acc_d;
                    if (sat) overflow_q <= 1'b1;
                end
            end
            if (state_q == StDrain && state_d == StDone) result_q <= acc_q;
        end
    end

    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign w_enable = (state_q == StDone);
    assign overflow = overflow_q;
    assign result   = result_q;

endmodule

// File: tb/tb_norm_engine.sv
// Bench for norm_engine: a reference model fills a scoreboard at each start, and results
// plus latencies are popped and compared when w_enable rises.
module tb_norm_engine;
    localparam int DATA_W = 27;
    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int ACC_W  = 64;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     r_enable = 1'b0;
    logic [1:0]               mode = 2'd0;
    logic [ADDR_W-1:0]        init_i = '0;
    logic [ADDR_W-1:0]        init_end = '0;
    logic signed [ACC_W-1:0]  init_acc = '0;
    logic                     controlArr = 1'b0;
    logic                     controlArrWEnable = 1'b0;
    logic [ADDR_W-1:0]        controlArrAddr = '0;
    logic signed [DATA_W-1:0] controlArrWData = '0;
    logic signed [DATA_W-1:0] controlArrRData;
    logic                     w_enable, busy, overflow;
    logic signed [ACC_W-1:0]  result;

    int vectors = 0;
    int miscompares = 0;

    longint                  mem_m [DEPTH];
    logic signed [ACC_W-1:0] exp_res_q [$];
    logic                    exp_ovf_q [$];
    int                      exp_cyc_q [$];

    norm_engine #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .r_enable         (r_enable),
        .mode             (mode),
        .init_i           (init_i),
        .init_end         (init_end),
        .init_acc         (init_acc),
        .controlArr       (controlArr),
        .controlArrWEnable(controlArrWEnable),
        .controlArrAddr   (controlArrAddr),
        .controlArrWData  (controlArrWData),
        .controlArrRData  (controlArrRData),
        .w_enable         (w_enable),
        .busy             (busy),
        .overflow         (overflow),
        .result           (result)
    );

    always #5 clk = ~clk;

    function automatic void model_run(input logic [1:0] md, input int s, input int e,
                                      input logic signed [63:0] acc0,
                                      output logic signed [63:0] res, output logic ovf);
        logic signed [65:0] sum;
        longint x, ax, t;
        int ec;
        res = acc0;
        ovf = 1'b0;
        ec = (e > DEPTH) ? DEPTH : e;
        if (md == 2'd3) return;
        for (int i = s; i < ec; i++) begin
            x  = mem_m[i];
            ax = (x < 0) ? -x : x;
            t  = (md == 2'd0) ? x * x : ax;
            if (md == 2'd2) begin
                if (ax > res) res = ax;
            end else begin
                sum = 66'(res) + 66'(t);
                if (sum > 66'(ACC_MAX)) begin
                    res = ACC_MAX;
                    ovf = 1'b1;
                end else begin
                    res = sum[63:0];
                end
            end
        end
    endfunction

    task automatic host_write(input int a, input logic signed [DATA_W-1:0] v);
        @(negedge clk);
        controlArr = 1'b1;
        controlArrWEnable = 1'b1;
        controlArrAddr = ADDR_W'(a);
        controlArrWData = v;
        mem_m[a] = longint'(v);
        @(negedge clk);
        controlArr = 1'b0;
        controlArrWEnable = 1'b0;
    endtask

    // Returns #1 after the edge that sampled r_enable.
    task automatic drive_start(input logic [1:0] md, input int s, input int e,
                               input logic signed [63:0] acc);
        @(negedge clk);
        r_enable = 1'b1;
        mode = md;
        init_i = ADDR_W'(s);
        init_end = ADDR_W'(e);
        init_acc = acc;
        @(posedge clk);
        #1;
        r_enable = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] md, input int s, input int e,
                             input logic signed [63:0] acc, input int stalls);
        logic signed [63:0] r;
        logic o;
        int ec, n;
        model_run(md, s, e, acc, r, o);
        ec = (e > DEPTH) ? DEPTH : e;
        n = (md == 2'd3 || s >= ec) ? 0 : ec - s;
        exp_res_q.push_back(r);
        exp_ovf_q.push_back(o);
        exp_cyc_q.push_back((n == 0) ? 2 : n + 4 + stalls);
        drive_start(md, s, e, acc);
    endtask

    task automatic wait_done(input string name);
        int cyc;
        logic signed [63:0] er;
        logic eo;
        int ec;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (w_enable !== 1'b1 && cyc < 3000);
        er = exp_res_q.pop_front();
        eo = exp_ovf_q.pop_front();
        ec = exp_cyc_q.pop_front();
        vectors++;
        if (w_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: w_enable=%b after %0d cycles", name, w_enable, cyc);
            return;
        end
        vectors++;
        if (cyc !== ec) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, ec);
        end
        vectors++;
        if (result !== er) begin
            miscompares++;
            $display("FAIL %s result: got %0d, want %0d", name, result, er);
        end
        vectors++;
        if (overflow !== eo) begin
            miscompares++;
            $display("FAIL %s overflow: got %b, want %b", name, overflow, eo);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy at done: got %b, want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (w_enable !== 1'b0) begin
            miscompares++; $display("FAIL reset w_enable: got %b, want 0", w_enable);
        end
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset busy: got %b, want 0", busy);
        end
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset overflow: got %b, want 0", overflow);
        end
        if (result !== 64'sd0) begin
            miscompares++; $display("FAIL reset result: got %0d, want 0", result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_host_port();
        int addrs [3] = '{0, 500, 999};
        for (int i = 0; i < DEPTH; i++) host_write(i, DATA_W'(i));
        foreach (addrs[k]) begin
            @(negedge clk);
            controlArr = 1'b1;
            controlArrAddr = ADDR_W'(addrs[k]);
            @(negedge clk);
            vectors++;
            if (controlArrRData !== DATA_W'(mem_m[addrs[k]])) begin
                miscompares++;
                $display("FAIL host_read[%0d]: got %0d, want %0d", addrs[k], controlArrRData,
                         mem_m[addrs[k]]);
            end
        end
        controlArr = 1'b0;
    endtask

    task automatic test_sum_squares();
        start_run(2'd0, 0, 1000, 64'sd0, 0);
        wait_done("sum_squares");
        vectors++;
        if (result !== 64'sd332833500) begin
            miscompares++; $display("FAIL sum_squares const: got %0d, want 332833500", result);
        end
    endtask

    task automatic test_abs_stall();
        start_run(2'd1, 10, 20, 64'sd5, 3);
        fork
            wait_done("abs_stall");
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                controlArr = 1'b1;
                controlArrAddr = ADDR_W'(900);
                repeat (3) @(negedge clk);
                controlArr = 1'b0;
            end
        join
        vectors++;
        if (result !== 64'sd150) begin
            miscompares++; $display("FAIL abs_stall const: got %0d, want 150", result);
        end
    endtask

    task automatic test_max_abs();
        host_write(3, {1'b1, 26'd0});
        start_run(2'd2, 0, 1000, 64'sd0, 0);
        wait_done("max_abs");
        vectors++;
        if (result !== 64'sh4000000) begin
            miscompares++; $display("FAIL max_abs const: got %0h, want 4000000", result);
        end
    endtask

    task automatic test_saturate();
        host_write(0, DATA_W'(4));
        start_run(2'd0, 0, 1, ACC_MAX - 64'sd9, 0);
        wait_done("saturate");
        vectors++;
        if (result !== ACC_MAX || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate const: got %0h ovf %b, want %0h ovf 1", result, overflow, ACC_MAX);
        end
        start_run(2'd1, 0, 1, 64'sd0, 0);
        vectors += 2;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL saturate clear: overflow got %b, want 0", overflow);
        end
        if (w_enable !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart flags: w_enable %b busy %b, want 0 1", w_enable, busy);
        end
        wait_done("after_saturate");
    endtask

    task automatic test_empty_busy_reset();
        start_run(2'd0, 500, 500, 64'sd77, 0);
        wait_done("empty_range");
        start_run(2'd1, 0, 10, 64'sd0, 0);
        fork
            wait_done("busy_start_ignored");
            begin
                repeat (4) @(negedge clk);
                r_enable = 1'b1;
                mode = 2'd3;
                init_i = '0;
                init_end = '0;
                init_acc = 64'sd999;
                @(negedge clk);
                r_enable = 1'b0;
            end
        join
        drive_start(2'd0, 0, 1000, 64'sd0);
        @(posedge clk);
        #2;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL long_run busy: got %b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (busy !== 1'b0 || w_enable !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset flags: busy %b w_enable %b ovf %b, want 0 0 0",
                     busy, w_enable, overflow);
        end
        if (result !== 64'sd0) begin
            miscompares++; $display("FAIL async_reset result: got %0d, want 0", result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(2'd1, 10, 20, 64'sd5, 0);
        wait_done("after_reset");
        vectors++;
        if (result !== 64'sd150) begin
            miscompares++; $display("FAIL after_reset const: got %0d, want 150", result);
        end
    endtask

    task automatic test_back_to_back_modes();
        logic signed [DATA_W-1:0] v;
        for (int i = 0; i < 16; i++) begin
            v = DATA_W'($urandom);
            if (i == 4) v = {1'b1, 26'd0};
            if (i == 5) v = {1'b0, {26{1'b1}}};
            host_write(i, v);
        end
        start_run(2'd0, 0, 16, 64'sd0, 0);
        wait_done("b2b_sq");
        start_run(2'd1, 0, 16, -64'sd1000, 0);
        wait_done("b2b_abs");
        start_run(2'd2, 2, 9, -64'sd5, 0);
        wait_done("b2b_max");
        start_run(2'd2, 0, 16, 64'sd100000000, 0);
        wait_done("b2b_max_floor");
        start_run(2'd3, 0, 16, 64'sd123, 0);
        wait_done("b2b_mode3");
        start_run(2'd1, 990, 1023, 64'sd0, 0);
        wait_done("b2b_clamp");
        start_run(2'd0, 15, 16, 64'sd0, 0);
        wait_done("b2b_single");
    endtask

    initial begin
        test_reset();
        test_host_port();
        test_sum_squares();
        test_abs_stall();
        test_max_abs();
        test_saturate();
        test_empty_busy_reset();
        test_back_to_back_modes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/norm_engine.md
NORM_ENGINE -- requirements
Module: norm_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 27, meaning signed element width.
REQ-002 SHALL have parameter DEPTH, default 1000, meaning number of array words.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning index width; ADDR_W >= clog2(DEPTH+1) (elaboration error otherwise).
REQ-004 SHALL have parameter ACC_W, default 64, meaning signed accumulator/result width; ACC_W >= 2*DATA_W.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port r_enable, input, 1, start pulse that latches mode, init_i, init_end and init_acc.
REQ-008 SHALL have port mode, input, 2, operation: 0 = sum of squares, 1 = sum of absolute values, 2 = max absolute value, 3 = reserved.
REQ-009 SHALL have ports init_i and init_end, input, ADDR_W each, inclusive start and exclusive end index.
REQ-010 SHALL have port init_acc, input, ACC_W signed, initial accumulator value.
REQ-011 SHALL have port controlArr, input, 1, host owns the memory port this cycle.
REQ-012 SHALL have ports controlArrWEnable (input, 1), controlArrAddr (input, ADDR_W), controlArrWData (input, DATA_W signed) and controlArrRData (output, DATA_W signed), the host memory port.
REQ-013 SHALL have port w_enable, output, 1, result valid (level).
REQ-014 SHALL have port busy, output, 1, computation in progress.
REQ-015 SHALL have port overflow, output, 1, sticky saturation flag for the current/last run.
REQ-016 SHALL have port result, output, ACC_W signed, final accumulator value.

Function
REQ-017 SHALL contain one DEPTH x DATA_W single-port RAM with synchronous write and one-cycle registered-address read; read data for the address presented in cycle t is valid in cycle t+1.
REQ-018 SHALL give the host priority on the RAM: when controlArr=1, address/write come from the control port; controlArrRData is valid the cycle after the host read and is don't-care when controlArr was 0.
REQ-019 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE; DONE -> RUN on r_enable; any state -> IDLE on rst_n=0.
REQ-020 SHALL, on r_enable in IDLE or DONE, latch the inputs, clear w_enable and overflow, set busy, load the accumulator with init_acc, and clamp end to min(init_end, DEPTH) on the next edge.
REQ-021 SHALL ignore r_enable while busy=1.
REQ-022 SHALL, in RUN, issue one read address per cycle from init_i upward, stalling issue (no address advance) in every cycle with controlArr=1.
REQ-023 SHALL carry a valid bit per pipeline stage (read, operate, accumulate) so that stall bubbles are never accumulated.
REQ-024 SHALL compute per element: mode 0 x*x (2*DATA_W signed, sign-extended); mode 1 |x| (DATA_W+1 bits, so -2^(DATA_W-1) is exact); mode 2 |x|.
REQ-025 SHALL accumulate: modes 0/1 acc + term; mode 2 acc = max(acc, |x|), init_acc acting as the floor.
REQ-026 SHALL saturate additions at +(2^(ACC_W-1)-1) and set overflow when saturation occurs; overflow stays set until the next accepted start.
REQ-027 SHALL enter DRAIN after the last address issues and DONE when all stage valids are clear, then drive result = acc, w_enable=1 and busy=0, holding them until the next start or reset.
REQ-028 SHALL, with N = end - start elements and no stalls, assert w_enable exactly N+4 cycles after the edge that sampled r_enable; each stall cycle adds one cycle.
REQ-029 SHALL treat start >= clamped end (empty range) and mode 3 as producing result = init_acc, overflow=0, with w_enable 2 cycles after start and no RAM reads.

Reset
REQ-030 SHALL, while rst_n=0, immediately force IDLE, w_enable=0, busy=0, overflow=0, result=0 and all valids 0; RAM contents are not reset.
REQ-031 SHALL abort any run on reset mid-operation; the first start after rst_n rises behaves as from power-up.

Verification
REQ-032 Host loads a[i]=i for i=0..999, starts mode 0 with init_i=0, init_end=1000, init_acc=0 -> result=332833500, w_enable at cycle 1004, overflow=0.
REQ-033 Same data, mode 1, init_i=10, init_end=20, init_acc=5, controlArr held 1 for 3 cycles mid-run -> result=150, w_enable at cycle 17.
REQ-034 a[3]=-2^26, mode 2, init_i=0, init_end=1000, init_acc=0 -> result=2^26 (0x4000000).
REQ-035 ACC_W=64, init_acc=2^63-10, mode 0, a[0]=4, range 0..1 -> result=2^63-1, overflow=1; next start clears overflow.
REQ-036 Start with init_i=500, init_end=500, then r_enable again while busy, then rst_n low at cycle 1 of a 1000-element run -> empty-range result=init_acc at cycle 2; busy-time start ignored; reset drives all outputs to 0 asynchronously.
